// File: rtl/ro_puf_sequencer_pkg.sv
// Shared definitions for the ring-oscillator PUF sequencer.
//   - state_t     : sequencer FSM state encoding
//   - *_DEF       : default parameter values used by the top and the interface
//   - CHALL_W     : challenge width seen by the scrambler
package ro_puf_sequencer_pkg;

  localparam int CHALL_W            = 8;
  localparam int N_BITS_DEF         = 8;
  localparam int SETTLE_CYCLES_DEF  = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int TMR_W_DEF          = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RACE,
    ST_CAPTURE,
    ST_STEP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ro_puf_sequencer_if.sv
// Bundle of host-side and datapath-side signals of the PUF sequencer.
//   host side     : start, chall_in -> response, ready, busy, timeout_err
//   datapath side : race_done, race_winner -> chall_out, scr_load, scr_step,
//                   ro_en, cnt_clr
// master : the sequencer (drives the strobes and the response)
// slave  : the host plus datapath environment
interface ro_puf_sequencer_if
  import ro_puf_sequencer_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
);

  logic               start;
  logic [CHALL_W-1:0] chall_in;
  logic               race_done;
  logic               race_winner;
  logic [CHALL_W-1:0] chall_out;
  logic               scr_load;
  logic               scr_step;
  logic               ro_en;
  logic               cnt_clr;
  logic [N_BITS-1:0]  response;
  logic               ready;
  logic               busy;
  logic               timeout_err;

  modport master (
    input  start, chall_in, race_done, race_winner,
    output chall_out, scr_load, scr_step, ro_en, cnt_clr,
           response, ready, busy, timeout_err
  );

  modport slave (
    output start, chall_in, race_done, race_winner,
    input  chall_out, scr_load, scr_step, ro_en, cnt_clr,
           response, ready, busy, timeout_err
  );

endinterface

// File: rtl/ro_puf_timer.sv
// Interval timer shared by the settle and race-timeout phases.
// Up-counter with synchronous clear; tc flags that the count equals the
// terminal value presented on tc_val, which the caller switches per phase.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to zero (otherwise the count advances)
//   tc_val   : terminal compare value
//   tc       : count == tc_val
module ro_puf_timer #(
  parameter int TMR_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [TMR_W-1:0] tc_val,
  output logic             tc
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == tc_val);

endmodule

// File: rtl/ro_puf_sequencer.sv
// Sequencer for the serialized ring-oscillator PUF datapath.
// On an accepted start it latches the challenge, pulses scr_load once, then
// runs N_BITS races (settle with counters cleared, race, capture), stepping
// the scrambler between races, and finally raises ready with the response.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ro_puf_sequencer_if.master (host and datapath signals)
// Every output is a register loaded from the next state, so no input
// reaches an output combinationally.
module ro_puf_sequencer
  import ro_puf_sequencer_pkg::*;
#(
  parameter int N_BITS         = N_BITS_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TMR_W          = TMR_W_DEF
) (
  input  logic clk,
  input  logic rst,
  ro_puf_sequencer_if.master bus
);

  localparam int               IDX_W      = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_BITS - 1);
  localparam logic [TMR_W-1:0] SETTLE_TC  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_TC = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] bit_idx;
  logic             cap_bit;
  logic             accept;
  logic             tmr_clr;
  logic             tmr_tc;
  logic [TMR_W-1:0] tmr_tc_val;

  // The timer compares against the settle length in SETTLE and against the
  // timeout everywhere else; only RACE uses the latter.
  assign tmr_tc_val = (state_q == ST_SETTLE) ? SETTLE_TC : TIMEOUT_TC;

  ro_puf_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .tc_val (tmr_tc_val),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    tmr_clr = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Clearing on the terminal cycle makes RACE start from zero.
        tmr_clr = tmr_tc;
        if (tmr_tc) begin
          state_d = ST_RACE;
        end
      end
      ST_RACE: begin
        tmr_clr = 1'b0;
        if (bus.race_done || tmr_tc) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d = (bit_idx == LAST_IDX) ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        state_d = ST_SETTLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      bit_idx         <= '0;
      bus.chall_out   <= '0;
      bus.response    <= '0;
      bus.timeout_err <= 1'b0;
      bus.scr_load    <= 1'b0;
      bus.scr_step    <= 1'b0;
      bus.ro_en       <= 1'b0;
      bus.cnt_clr     <= 1'b1;
      bus.ready       <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus.scr_load <= (state_d == ST_LOAD);
      bus.scr_step <= (state_d == ST_STEP);
      bus.ro_en    <= (state_d == ST_SETTLE) || (state_d == ST_RACE);
      bus.cnt_clr  <= (state_d != ST_RACE);
      bus.ready    <= (state_d == ST_DONE);
      bus.busy     <= (state_d == ST_LOAD) || (state_d == ST_SETTLE) ||
                      (state_d == ST_RACE) || (state_d == ST_CAPTURE) ||
                      (state_d == ST_STEP);

      if (accept) begin
        bus.chall_out   <= bus.chall_in;
        bus.response    <= '0;
        bus.timeout_err <= 1'b0;
        bit_idx         <= '0;
      end

      // A finishing race wins over a coincident timeout.
      if ((state_q == ST_RACE) && !bus.race_done && tmr_tc) begin
        bus.timeout_err <= 1'b1;
      end

      if (state_q == ST_CAPTURE) begin
        bus.response[bit_idx] <= cap_bit;
        if (bit_idx != LAST_IDX) begin
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

  // Sampled every RACE cycle; the value from the exit cycle is what CAPTURE
  // stores: the winner if the arbiter finished, otherwise 0 (timeout).
  always_ff @(posedge clk) begin
    if (state_q == ST_RACE) begin
      cap_bit <= bus.race_done & bus.race_winner;
    end
  end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Bench for ro_puf_sequencer: directed sequences with an arbiter model that
// finishes each race after a programmed number of RACE cycles (0 = never).
// Expected sequence results and per-race lengths are queued when a start is
// issued; a monitor pops and compares them when races end and ready rises.
module tb_ro_puf_sequencer;
  import ro_puf_sequencer_pkg::*;

  localparam int N  = 8;
  localparam int S  = 4;
  localparam int TO = 1024;

  typedef struct {
    logic [7:0] resp;
    logic       terr;
    logic [7:0] chall;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ro_puf_sequencer_if #(.N_BITS(N)) ifc();

  ro_puf_sequencer #(
    .N_BITS         (N),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (TO),
    .TMR_W          (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  exp_t sb[$];
  int   race_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   n_load = 0;
  int   n_step = 0;
  int   race_idx = 0;
  int   race_cnt = 0;
  int   done_at[N];
  logic win[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int exp_lat();
    int l = 1;
    for (int k = 0; k < N; k++) l += S + ((done_at[k] == 0) ? TO : done_at[k]) + 1;
    return l + (N - 1) + 1;
  endfunction

  // Arbiter model, strobe counters and scoreboard monitor.
  initial begin
    logic prev_race = 1'b0;
    logic prev_ready = 1'b0;
    logic in_race;
    int   idx;
    exp_t e;
    ifc.race_done = 1'b0;
    ifc.race_winner = 1'b0;
    forever begin
      @(negedge clk);
      in_race = ifc.ro_en && !ifc.cnt_clr;
      if (ifc.scr_load) begin
        n_load++;
        race_idx = 0;
      end
      if (ifc.scr_step) n_step++;
      if (prev_race && !in_race && ifc.busy) begin
        if (race_q.size() > 0) check("race_len", race_cnt, race_q.pop_front());
        else check("race_extra", race_q.size(), 1);
        race_idx++;
      end
      if (in_race && !prev_race) race_cnt = 1;
      else if (in_race) race_cnt++;
      idx = (race_idx < N) ? race_idx : N - 1;
      ifc.race_done = in_race && (done_at[idx] != 0) && (race_cnt == done_at[idx]);
      ifc.race_winner = win[idx];
      if (ifc.ready && !prev_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("response", ifc.response, e.resp);
          check("timeout_err", ifc.timeout_err, e.terr);
          check("chall_out", ifc.chall_out, e.chall);
          check("latency", cyc - start_cyc, e.lat);
          check("scr_load_cnt", n_load, 1);
          check("scr_step_cnt", n_step, N - 1);
        end else begin
          check("ready_unexpected", sb.size(), 1);
        end
      end
      prev_race = in_race;
      prev_ready = ifc.ready;
    end
  end

  task automatic set_races(input int d, input logic [7:0] w);
    for (int k = 0; k < N; k++) begin
      done_at[k] = d;
      win[k] = w[k];
    end
  endtask

  task automatic issue(input logic [7:0] ch, input logic [7:0] resp, input logic terr);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.chall_in = ch;
    start_cyc = cyc;
    n_load = 0;
    n_step = 0;
    sb.push_back('{resp, terr, ch, exp_lat()});
    for (int k = 0; k < N; k++) race_q.push_back((done_at[k] == 0) ? TO : done_at[k]);
    @(negedge clk);
    ifc.start = 1'b0;
    check("post_start_ready", ifc.ready, 0);
    check("post_start_busy", ifc.busy, 1);
    check("post_start_resp", ifc.response, 0);
    check("post_start_load", ifc.scr_load, 1);
    check("post_start_chall", ifc.chall_out, ch);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ifc.ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ready_seen", ifc.ready, 1);
  endtask

  // racing=1 waits for RACE, racing=0 for SETTLE
  task automatic wait_phase(input logic racing);
    int n = 0;
    while (!(ifc.ro_en && (ifc.cnt_clr != racing)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("phase_seen", ifc.ro_en && (ifc.cnt_clr != racing), 1);
  endtask

  task automatic pulse_busy_start();
    ifc.start = 1'b1;
    ifc.chall_in = 8'h3C;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int n;
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.chall_in = 8'h00;
    set_races(20, 8'b0100_1101);
    repeat (2) @(negedge clk);
    check("rst_ro_en", ifc.ro_en, 0);
    check("rst_cnt_clr", ifc.cnt_clr, 1);
    check("rst_busy", ifc.busy, 0);
    check("rst_ready", ifc.ready, 0);
    check("rst_response", ifc.response, 0);
    check("rst_chall_out", ifc.chall_out, 0);
    check("rst_strobes", {ifc.scr_load, ifc.scr_step, ifc.timeout_err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sequence, with ignored start pulses in SETTLE and RACE.
    issue(8'hA5, 8'b0100_1101, 1'b0);
    wait_phase(1'b0);
    pulse_busy_start();
    wait_phase(1'b1);
    pulse_busy_start();
    wait_ready();

    // Race 3 never finishes: timeout, bit 3 forced to 0.
    set_races(20, 8'b0100_1101);
    done_at[3] = 0;
    issue(8'hA5, 8'b0100_0101, 1'b1);
    wait_ready();

    // Race 2 finishes on the final timer cycle with winner 1.
    set_races(20, 8'b0100_1101);
    done_at[2] = TO;
    issue(8'hA5, 8'b0100_1101, 1'b0);
    wait_ready();

    // Restart from DONE with a new challenge.
    set_races(20, 8'b0100_1101);
    issue(8'h0F, 8'b0100_1101, 1'b0);
    wait_ready();

    // Asynchronous reset in the middle of race 5.
    issue(8'h0F, 8'b0100_1101, 1'b0);
    n = 0;
    while (!(race_idx == 5 && ifc.ro_en && !ifc.cnt_clr) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("race5_reached", race_idx, 5);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ro_en", ifc.ro_en, 0);
    check("arst_cnt_clr", ifc.cnt_clr, 1);
    check("arst_busy", ifc.busy, 0);
    check("arst_ready", ifc.ready, 0);
    check("arst_response", ifc.response, 0);
    check("arst_chall_out", ifc.chall_out, 0);
    sb.delete();
    race_q.delete();
    @(negedge clk);
    rst = 1'b0;
    viol = 0;
    repeat (60) begin
      @(negedge clk);
      if (ifc.scr_load || ifc.scr_step || ifc.ro_en || ifc.ready || ifc.busy) viol++;
    end
    check("quiet_after_reset", viol, 0);

    // Recovery after reset.
    set_races(20, 8'b0100_1101);
    issue(8'hA5, 8'b0100_1101, 1'b0);
    wait_ready();
    repeat (3) @(negedge clk);
    check("queue_drained", sb.size() + race_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
